// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between the I-cache refill path and the D-cache
// refill/writeback path, running one whole-line word burst per grant.
module cache_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    localparam int BW = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic [BW-1:0]         i_beat,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [BW-1:0]         d_beat,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t                state, state_nx;
    logic                  owner_d, owner_d_nx;
    logic                  we, we_nx;
    logic [ADDR_WIDTH-1:0] base, base_nx;
    logic [BW-1:0]         beat, beat_nx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            we      <= 1'b0;
            base    <= '0;
            beat    <= '0;
        end else begin
            state   <= state_nx;
            owner_d <= owner_d_nx;
            we      <= we_nx;
            base    <= base_nx;
            beat    <= beat_nx;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx   = state;
        owner_d_nx = owner_d;
        we_nx      = we;
        base_nx    = base;
        beat_nx    = beat;
        case (state)
            IDLE: begin
                beat_nx = '0;
                // D wins ties: the memory-stage instruction is the older one.
                if (d_req) begin
                    owner_d_nx = 1'b1;
                    we_nx      = d_we;
                    base_nx    = d_addr & LINE_MASK;
                    state_nx   = BURST;
                end else if (i_req) begin
                    owner_d_nx = 1'b0;
                    we_nx      = 1'b0;
                    base_nx    = i_addr & LINE_MASK;
                    state_nx   = BURST;
                end
            end
            BURST: begin
                if (mem_ready) begin
                    beat_nx = beat + BW'(1);
                    if (beat == LAST_BEAT) state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic in_burst;
    logic rd_beat;

    assign in_burst  = (state == BURST);
    assign rd_beat   = in_burst && mem_ready && !we;

    assign mem_req   = in_burst;
    assign mem_we    = in_burst && we;
    assign mem_addr  = in_burst ? (base | ADDR_WIDTH'({beat, 2'b00})) : '0;
    assign mem_wdata = (in_burst && owner_d) ? d_wdata : '0;

    assign i_rvalid  = rd_beat && !owner_d;
    assign d_rvalid  = rd_beat && owner_d;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign i_beat    = (in_burst && !owner_d) ? beat : '0;
    assign d_beat    = (in_burst && owner_d) ? beat : '0;
    assign i_done    = (state == DONE) && !owner_d;
    assign d_done    = (state == DONE) && owner_d;
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: a transaction-level model predicts every output each
// cycle, and directed scenarios pin the model with hand-computed literals.
module tb_cache_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          mem_ready;
    logic          i_rvalid, i_done, d_rvalid, d_done, mem_req, mem_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [BW-1:0] i_beat, d_beat;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_beat(i_beat), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_beat(d_beat), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory and D-cache stand-ins: 0 = never ready, 1 = zero-wait, 2 = every 3rd cycle.
    int cyc = 0;
    int ready_mode = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign mem_ready = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? (cyc % 3 == 0) : 1'b0;
    assign mem_rdata = mem_addr ^ 32'hC0DE_0000;
    assign d_wdata   = 32'hA0 + 32'(d_beat);

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Transaction model: phase -1 = no grant, 0..LW-1 = beat in flight, LW = done strobe.
    int            m_phase = -1;
    logic          m_d = 1'b0, m_we = 1'b0;
    logic [AW-1:0] m_base = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = -1; m_d = 1'b0; m_we = 1'b0; m_base = '0;
        end else if (m_phase < 0) begin
            if (d_req) begin
                m_d = 1'b1; m_we = d_we; m_base = d_addr - (d_addr % (LW * 4)); m_phase = 0;
            end else if (i_req) begin
                m_d = 1'b0; m_we = 1'b0; m_base = i_addr - (i_addr % (LW * 4)); m_phase = 0;
            end
        end else if (m_phase < LW) begin
            if (mem_ready) m_phase = m_phase + 1;
        end else begin
            m_phase = -1;
        end
    end

    // Observation logs used by the directed literal checks.
    int            n_irv, n_drv, n_idone, n_ddone, idone_cyc, ddone_cyc;
    logic [AW-1:0] log_addr[$];
    int            log_d[$], log_beat[$], log_cyc[$];
    logic [AW-1:0] wlog_addr[$];
    logic [DW-1:0] wlog_data[$];

    task automatic clr_log();
        n_irv = 0; n_drv = 0; n_idone = 0; n_ddone = 0; idone_cyc = 0; ddone_cyc = 0;
        log_addr.delete(); log_d.delete(); log_beat.delete(); log_cyc.delete();
        wlog_addr.delete(); wlog_data.delete();
    endtask

    logic          in_b;
    logic [AW-1:0] e_addr;

    always @(negedge clk) begin
        in_b   = (m_phase >= 0) && (m_phase < LW);
        e_addr = in_b ? m_base + 32'(4 * m_phase) : '0;
        check("busy",      busy,      m_phase >= 0);
        check("mem_req",   mem_req,   in_b);
        check("mem_we",    mem_we,    in_b && m_we);
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_wdata", mem_wdata, (in_b && m_d) ? 64'(32'hA0 + m_phase) : 64'd0);
        check("i_rvalid",  i_rvalid,  in_b && !m_d && !m_we && mem_ready);
        check("d_rvalid",  d_rvalid,  in_b && m_d && !m_we && mem_ready);
        if (in_b && !m_we && mem_ready)
            check("rdata", m_d ? d_rdata : i_rdata, e_addr ^ 32'hC0DE_0000);
        check("i_beat",    i_beat,    (in_b && !m_d) ? 64'(m_phase) : 64'd0);
        check("d_beat",    d_beat,    (in_b && m_d) ? 64'(m_phase) : 64'd0);
        check("i_done",    i_done,    m_phase == LW && !m_d);
        check("d_done",    d_done,    m_phase == LW && m_d);

        if (i_rvalid) begin
            n_irv++; log_addr.push_back(mem_addr); log_d.push_back(0);
            log_beat.push_back(int'(i_beat)); log_cyc.push_back(cyc);
        end
        if (d_rvalid) begin
            n_drv++; log_addr.push_back(mem_addr); log_d.push_back(1);
            log_beat.push_back(int'(d_beat)); log_cyc.push_back(cyc);
        end
        if (mem_req && mem_we && mem_ready) begin
            wlog_addr.push_back(mem_addr); wlog_data.push_back(mem_wdata);
        end
        if (i_done) begin n_idone++; idone_cyc = cyc; end
        if (d_done) begin n_ddone++; ddone_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns #1 after the edge that leaves the done cycle, i.e. in the IDLE cycle.
    task automatic run_until_done(input bit side_d, input int budget);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (side_d ? d_done : i_done) found = 1'b1;
        end
        check(side_d ? "d_done_seen" : "i_done_seen", found, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_i_beat(input int b, input int budget);
        bit found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (i_rvalid && int'(i_beat) == b) found = 1'b1;
        end
        check("i_beat_seen", found, 1);
    endtask

    initial begin
        clr_log();
        #12;
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);

        // I refill, zero-wait memory.
        clr_log();
        ready_mode = 1;
        i_req = 1'b1; i_addr = 32'h0000_1234;
        run_until_done(1'b0, 20);
        i_req = 1'b0;
        check("i1_nbeats", log_addr.size(), 4);
        for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
            check("i1_addr", log_addr[k], 32'h1230 + 4 * k);
            check("i1_beat", log_beat[k], k);
            check("i1_side", log_d[k], 0);
        end
        if (log_cyc.size() == 4) begin
            check("i1_contig", log_cyc[3] - log_cyc[0], 3);
            check("i1_done_lat", idone_cyc - log_cyc[3], 1);
        end
        check("i1_ndone", n_idone, 1);

        // Simultaneous requests: D wins, I follows after done + one IDLE cycle.
        clr_log();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        i_req = 1'b1; i_addr = 32'h0000_3008;
        run_until_done(1'b1, 20);
        d_req = 1'b0;
        run_until_done(1'b0, 20);
        i_req = 1'b0;
        check("arb_nbeats", log_addr.size(), 8);
        if (log_addr.size() == 8) begin
            for (int k = 0; k < 4; k++) begin
                check("arb_d_addr", log_addr[k], 32'h2000 + 4 * k);
                check("arb_d_side", log_d[k], 1);
                check("arb_i_addr", log_addr[k + 4], 32'h3000 + 4 * k);
                check("arb_i_side", log_d[k + 4], 0);
            end
            check("arb_gap", log_cyc[4] - ddone_cyc, 2);
        end
        check("arb_ndone", n_ddone + n_idone, 2);

        // D writeback with two wait states per beat.
        clr_log();
        ready_mode = 2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_4018;
        run_until_done(1'b1, 60);
        d_req = 1'b0; d_we = 1'b0;
        ready_mode = 1;
        check("wb_drv", n_drv, 0);
        check("wb_ndone", n_ddone, 1);
        check("wb_nwrites", wlog_addr.size(), 4);
        for (int k = 0; k < 4 && k < wlog_addr.size(); k++) begin
            check("wb_addr", wlog_addr[k], 32'h4010 + 4 * k);
            check("wb_data", wlog_data[k], 32'hA0 + k);
        end

        // Requester withdraws after beat 1; the burst still runs to the end.
        clr_log();
        i_req = 1'b1; i_addr = 32'h0000_5004;
        wait_i_beat(1, 20);
        @(posedge clk); #1;
        i_req = 1'b0;
        run_until_done(1'b0, 20);
        check("drop_nbeats", n_irv, 4);
        check("drop_ndone", n_idone, 1);
        if (log_addr.size() == 4) check("drop_last_addr", log_addr[3], 32'h500C);
        tick(2);
        check("drop_idle", busy, 0);

        // Asynchronous reset in the middle of beat 2.
        clr_log();
        i_req = 1'b1; i_addr = 32'h0000_6000;
        wait_i_beat(2, 20);
        #1;
        rst_n = 1'b0; i_req = 1'b0;
        #1;
        check("ar_mem_req", mem_req, 0);
        check("ar_busy", busy, 0);
        check("ar_i_rvalid", i_rvalid, 0);
        check("ar_mem_addr", mem_addr, 0);
        check("ar_i_beat", i_beat, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("ar_stay_idle", busy, 0);
        clr_log();
        i_req = 1'b1; i_addr = 32'h0000_6000;
        run_until_done(1'b0, 20);
        i_req = 1'b0;
        check("ar_restart_n", log_addr.size(), 4);
        if (log_addr.size() > 0) begin
            check("ar_restart_addr", log_addr[0], 32'h6000);
            check("ar_restart_beat", log_beat[0], 0);
        end

        // Stray mem_ready while idle.
        clr_log();
        tick(5);
        check("stray_irv", n_irv, 0);
        check("stray_drv", n_drv, 0);
        check("stray_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
